// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor that ripples its carry
// through a register, CHUNK bits per clock, with valid/ready on both sides.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for operands; in_ready high
//   RUN   | one chunk per edge, k = 0 .. N-1, carry held in carry_q
//   DONE  | result presented on sum/carry/ovf; out_valid high until out_ready
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             consume;
  logic             last_chunk;

  int               base;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             c_into_msb;
  logic [WIDTH-1:0] acc_next;

  // Reset gates in_ready so nothing is offered while rst_n is held low.
  assign in_ready   = rst_n && (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && (state == IDLE);
  assign consume    = out_ready && (state == DONE);
  assign last_chunk = (k == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (consume) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One chunk of the ripple: slice the latched operands at chunk k and add
  // with the registered carry. The carry into the MSB is recovered from the
  // sum bit, which is only meaningful on the last chunk.
  always_comb begin
    base              = int'(k) * CHUNK;
    a_c               = a_q[base +: CHUNK];
    b_c               = b_q[base +: CHUNK];
    {c_out, s_c}      = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    c_into_msb        = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];
    acc_next          = acc;
    acc_next[base +: CHUNK] = s_c;
  end

  // Operand latch, carry register and chunk index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k       <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            k       <= '0;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_q <= c_out;
          if (!last_chunk) begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers; they load only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN && last_chunk) begin
      sum   <= acc_next;
      carry <= c_out;
      ovf   <= c_into_msb ^ c_out;
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and randomized checks of chunked_adder against an
// integer-arithmetic reference model.
module tb_chunked_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  int n_checks = 0;
  int n_pass   = 0;

  chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic ts, input logic tc,
                       output logic [15:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, r, sr;
    ua = int'(ta);
    ub = int'(tb_v);
    sa = $signed(ta);
    sb = $signed(tb_v);
    if (!ts) begin
      r  = ua + ub + int'(tc);
      sr = sa + sb + int'(tc);
      ec = (r > 65535);
    end else begin
      r  = ua - ub - int'(tc);
      sr = sa - sb - int'(tc);
      ec = (r >= 0);
    end
    es = r[15:0];
    eo = (sr > 32767) || (sr < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, optionally stall the
  // consumer for `stall` cycles while offering fresh operands that must be
  // ignored.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tc, input int stall);
    logic [15:0] es;
    logic        ec, eo;
    int          cyc;
    model(ta, tb_v, ts, tc, es, ec, eo);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_v;
    sub       = ts;
    cin       = tc;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    sub      = 1'($urandom);
    cin      = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(N));
    check("sum", 32'(sum), 32'(es));
    check("carry", 32'(carry), 32'(ec));
    check("ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'(es));
      check("stall_flags", {30'd0, carry, ovf}, {30'd0, ec, eo});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("single_out_valid", 32'(out_valid), 32'd0);
    check("in_ready_after_consume", 32'(in_ready), 32'd1);
    check("sum_held_idle", 32'(sum), 32'(es));
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;

    repeat (3) tick();
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", {30'd0, carry, ovf}, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
    run_op(16'h0005, 16'h0002, 1'b1, 1'b1, 0);

    run_op(16'hABCD, 16'h1357, 1'b0, 1'b1, 10);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0);

    // Reset two cycles after acceptance: the operation must vanish.
    a        = 16'h4444;
    b        = 16'h3333;
    sub      = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_out_valid", 32'(out_valid), 32'd0);
    end
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_flags", {30'd0, carry, ovf}, 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (out_valid) cyc++;
    end
    check("midrst_no_pulse", 32'(cyc), 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    check("post_rst_sum_const", 32'(sum), 32'h2345);

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
